multicycle_exec_unit: RTL

- Parametrised successor to the IR/register-file/ALU datapath slice.
- Adds an internal multicycle sequencer (IDLE→DECODE→EXEC→WB) with a valid/ready instruction handshake.
- Instruction register, A/B operand latches, ALU-out latch and register-file writeback, so the block executes one MIPS-style ALU/jal instruction end to end.
- Sits between the fetch stage (supplies instr + pc) and the core controller (consumes result/zero).

---
 rtl/mce_pkg.sv | 19 +
 rtl/mce_regfile.sv | 34 +++
 rtl/multicycle_exec_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mce_pkg.sv
// rtl/mce_pkg.sv - shared opcodes, ALU ops and sequencer states for the multicycle exec unit
package mce_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [2:0] {ADD, SUB, AND, OR, SLT} alu_op_t;

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

endpackage

// File: rtl/mce_regfile.sv
// rtl/mce_regfile.sv - NREGS x WIDTH register file, two async reads, one sync write, R0 tied to zero
import mce_pkg::*;

module mce_regfile #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata
);

  logic [WIDTH-1:0] regs [NREGS];

  // Write port; R0 is never stored so it always reads back as zero
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/multicycle_exec_unit.sv
// rtl/multicycle_exec_unit.sv - IDLE/DECODE/EXEC/WB sequenced ALU and jal execution slice
import mce_pkg::*;

module multicycle_exec_unit #(
  parameter int WIDTH    = 32,
  parameter int NREGS    = 32,
  parameter int LINK_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] pc,
  input  logic             ext_we,
  input  logic [4:0]       ext_waddr,
  input  logic [WIDTH-1:0] ext_wdata,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int AW = $clog2(NREGS);

  state_t           state, state_next;
  logic [31:0]      ir;
  logic [WIDTH-1:0] pc_q, a_q, b_q, imm_q, alu_out, alu_result, src_b;
  logic [WIDTH-1:0] rdata_a, rdata_b;
  logic             accept;

  logic [5:0]       opcode, funct;
  alu_op_t          alu_op;
  logic [AW-1:0]    dest;
  logic             use_imm, imm_zext, is_jal, illegal_dec;

  logic             int_we, rf_we;
  logic [AW-1:0]    rf_waddr;
  logic [WIDTH-1:0] rf_wdata;

  assign accept = instr_valid & instr_ready;
  assign opcode = ir[31:26];
  assign funct  = ir[5:0];

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and handshake: only IDLE can take a new instruction
  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_next = DECODE;
      end
      DECODE:  state_next = EXEC;
      EXEC:    state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Instruction decode from the held IR
  always_comb begin
    alu_op      = ADD;
    dest        = ir[11 +: AW];
    use_imm     = 1'b0;
    imm_zext    = 1'b0;
    is_jal      = 1'b0;
    illegal_dec = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD:   alu_op = ADD;
          F_SUB:   alu_op = SUB;
          F_AND:   alu_op = AND;
          F_OR:    alu_op = OR;
          F_SLT:   alu_op = SLT;
          default: illegal_dec = 1'b1;
        endcase
      end
      OP_ADDI: begin
        use_imm = 1'b1;
        dest    = ir[16 +: AW];
      end
      OP_ORI: begin
        alu_op   = OR;
        use_imm  = 1'b1;
        imm_zext = 1'b1;
        dest     = ir[16 +: AW];
      end
      OP_JAL: begin
        is_jal = 1'b1;
        dest   = AW'(LINK_REG);
      end
      default: illegal_dec = 1'b1;
    endcase
  end

  assign src_b = is_jal ? WIDTH'(4) : (use_imm ? imm_q : b_q);

  // ALU; unsupported instructions produce zero
  always_comb begin
    alu_result = '0;
    case (alu_op)
      ADD:     alu_result = a_q + src_b;
      SUB:     alu_result = a_q - src_b;
      AND:     alu_result = a_q & src_b;
      OR:      alu_result = a_q | src_b;
      SLT:     alu_result = WIDTH'($signed(a_q) < $signed(src_b));
      default: alu_result = '0;
    endcase
    if (illegal_dec) alu_result = '0;
  end

  // Datapath latches and result outputs, each loaded in its own state
  always_ff @(posedge clk) begin
    if (reset) begin
      ir           <= '0;
      pc_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      imm_q        <= '0;
      alu_out      <= '0;
      result_valid <= 1'b0;
      result       <= '0;
      zero         <= 1'b1;
      illegal      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (accept) begin
        ir   <= instr;
        pc_q <= pc;
      end
      if (state == DECODE) begin
        a_q   <= is_jal ? pc_q : rdata_a;
        b_q   <= rdata_b;
        imm_q <= imm_zext ? WIDTH'(ir[15:0]) : WIDTH'($signed(ir[15:0]));
      end
      if (state == EXEC) alu_out <= alu_result;
      if (state == WB) begin
        result_valid <= 1'b1;
        result       <= alu_out;
        zero         <= (alu_out == '0);
        illegal      <= illegal_dec;
      end
    end
  end

  // Writeback owns the write port in WB; an external write that cycle is dropped
  assign int_we   = (state == WB) && !illegal_dec;
  assign rf_we    = int_we | ext_we;
  assign rf_waddr = int_we ? dest : ext_waddr[AW-1:0];
  assign rf_wdata = int_we ? alu_out : ext_wdata;

  mce_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .raddr_a (ir[21 +: AW]),
    .raddr_b (ir[16 +: AW]),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata)
  );

endmodule
